// File: rtl/inst_decode_stage.sv
// Decode stage: 2-entry FIFO of fully decoded RV32I instructions.
// Define ILLEGAL_TRAP_EN to flag and squash illegal encodings.
module inst_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] optype,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] pc_out,
  output logic [31:0] immI,
  output logic [31:0] immS,
  output logic [31:0] immB,
  output logic [31:0] immU,
  output logic [31:0] immJ,
  output logic        illegal
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [10:0] optype;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        illegal;
  } entry_t;

  function automatic entry_t decode(
    input logic [31:0] i,
    input logic [31:0] pc
  );
    entry_t     e;
    logic [10:0] ot;
    logic        bad;
    ot = '0;
    case (i[6:0])
      7'b0110011: ot = 11'h001;
      7'b0010011: ot = 11'h002;
      7'b0000011: ot = 11'h004;
      7'b0100011: ot = 11'h008;
      7'b1100011: ot = 11'h010;
      7'b1101111: ot = 11'h020;
      7'b1100111: ot = 11'h040;
      7'b0110111: ot = 11'h080;
      7'b0010111: ot = 11'h100;
      7'b1110011: ot = 11'h200;
      7'b0001111: ot = 11'h400;
      default:    ot = '0;
    endcase
`ifdef ILLEGAL_TRAP_EN
    // every listed opcode ends in 2'b11, so ot==0 also covers bad [1:0]
    bad = (ot == '0);
    if (ot[0]) begin
      if (i[31:25] != 7'b0000000 && i[31:25] != 7'b0100000)
        bad = 1'b1;
      if (i[31:25] == 7'b0100000 &&
          i[14:12] != 3'b000 && i[14:12] != 3'b101)
        bad = 1'b1;
    end
    if (ot[4] && (i[14:12] == 3'b010 || i[14:12] == 3'b011))
      bad = 1'b1;
    if (ot[2] && (i[14:12] == 3'b011 || i[14:12] == 3'b110 ||
                  i[14:12] == 3'b111))
      bad = 1'b1;
    if (ot[3] && i[14:12] > 3'b010)
      bad = 1'b1;
    if (ot[6] && i[14:12] != 3'b000)
      bad = 1'b1;
    if (bad)
      ot = '0;
`else
    bad = 1'b0;
`endif
    e.optype  = ot;
    e.funct3  = i[14:12];
    e.funct7  = i[31:25];
    e.rs1     = i[19:15];
    e.rs2     = i[24:20];
    e.rd      = i[11:7];
    e.pc      = pc;
    e.imm_i   = {{20{i[31]}}, i[31:20]};
    e.imm_s   = {{20{i[31]}}, i[31:25], i[11:7]};
    e.imm_b   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    e.imm_u   = {i[31:12], 12'b0};
    e.imm_j   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e.illegal = bad;
    return e;
  endfunction

  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  entry_t     e0_q, e0_d;
  entry_t     e1_q, e1_d;
  entry_t     dec;
  logic       push, pop;

  always_comb begin
    dec        = decode(in_instr, in_pc);
    push       = in_valid && in_ready_q && !flush;
    pop        = (count_q != EMPTY) && out_ready;
    count_d    = count_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    if (flush) begin
      count_d = EMPTY;
    end else begin
      case (count_q)
        EMPTY: begin
          if (push) begin
            e0_d    = dec;
            count_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            e0_d = dec;
          end else if (push) begin
            e1_d    = dec;
            count_d = TWO;
          end else if (pop) begin
            count_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            e0_d = e1_q;
            if (push)
              e1_d = dec;
            else
              count_d = ONE;
          end
        end
        default: count_d = EMPTY;
      endcase
    end
    in_ready_d = (count_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= EMPTY;
      in_ready_q <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != EMPTY);
  assign optype    = e0_q.optype;
  assign funct3    = e0_q.funct3;
  assign funct7    = e0_q.funct7;
  assign rs1       = e0_q.rs1;
  assign rs2       = e0_q.rs2;
  assign rd        = e0_q.rd;
  assign pc_out    = e0_q.pc;
  assign immI      = e0_q.imm_i;
  assign immS      = e0_q.imm_s;
  assign immB      = e0_q.imm_b;
  assign immU      = e0_q.imm_u;
  assign immJ      = e0_q.imm_j;
  assign illegal   = e0_q.illegal;

endmodule
